// File: rtl/pipe_io_master.sv
// Bus master that polls the switch and key registers, then refreshes the six
// hex displays and the LED bank from the captured snapshots, one pass at a time.
module pipe_io_master (
  input  logic        resetn,
  input  logic        ram_clock,
  input  logic        enable,
  input  logic        grant,
  input  logic [31:0] rdata,
  output logic        req,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic        we,
  output logic        busy,
  output logic        done,
  output logic [9:0]  sw_snap,
  output logic [2:0]  key_snap,
  output logic [7:0]  pass_cnt
);

  localparam logic [31:0] ADDR_SW  = 32'hFFFF_FF00;
  localparam logic [31:0] ADDR_KEY = 32'hFFFF_FF10;
  localparam logic [31:0] ADDR_H0  = 32'hFFFF_FF20;
  localparam logic [31:0] ADDR_H1  = 32'hFFFF_FF30;
  localparam logic [31:0] ADDR_H2  = 32'hFFFF_FF40;
  localparam logic [31:0] ADDR_H3  = 32'hFFFF_FF50;
  localparam logic [31:0] ADDR_H4  = 32'hFFFF_FF60;
  localparam logic [31:0] ADDR_H5  = 32'hFFFF_FF70;
  localparam logic [31:0] ADDR_LED = 32'hFFFF_FF80;
  localparam logic [31:0] BLANK    = 32'h0000_007F;

  typedef enum logic [3:0] {
    IDLE, RD_SW, WT_SW, RD_KEY, WT_KEY,
    WR_H0, WR_H1, WR_H2, WR_H3, WR_H4, WR_H5, WR_LED, DONE
  } state_t;

  state_t state, state_nxt;
  logic   wr_state;
  logic   unused_rdata;

  assign unused_rdata = ^{rdata[31:10], rdata[0]};

  // Active-low segments, bit 6 = g ... bit 0 = a.
  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_ff @(posedge ram_clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // A lost grant in a wait state invalidates the registered read, so the read is reissued.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RD_SW;
      RD_SW:   if (grant) state_nxt = WT_SW;
      WT_SW:   state_nxt = grant ? RD_KEY : RD_SW;
      RD_KEY:  if (grant) state_nxt = WT_KEY;
      WT_KEY:  state_nxt = grant ? WR_H0 : RD_KEY;
      WR_H0:   if (grant) state_nxt = WR_H1;
      WR_H1:   if (grant) state_nxt = WR_H2;
      WR_H2:   if (grant) state_nxt = WR_H3;
      WR_H3:   if (grant) state_nxt = WR_H4;
      WR_H4:   if (grant) state_nxt = WR_H5;
      WR_H5:   if (grant) state_nxt = WR_LED;
      WR_LED:  if (grant) state_nxt = DONE;
      DONE:    state_nxt = enable ? RD_SW : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    addr     = '0;
    wdata    = '0;
    wr_state = 1'b0;
    case (state)
      RD_SW, WT_SW:   addr = ADDR_SW;
      RD_KEY, WT_KEY: addr = ADDR_KEY;
      WR_H0: begin
        addr     = ADDR_H0;
        wdata    = {25'b0, seg(sw_snap[3:0])};
        wr_state = 1'b1;
      end
      WR_H1: begin
        addr     = ADDR_H1;
        wdata    = {25'b0, seg(sw_snap[7:4])};
        wr_state = 1'b1;
      end
      WR_H2: begin
        addr     = ADDR_H2;
        wdata    = {25'b0, seg({2'b0, sw_snap[9:8]})};
        wr_state = 1'b1;
      end
      WR_H3: begin
        addr     = ADDR_H3;
        wdata    = {25'b0, seg({1'b0, key_snap})};
        wr_state = 1'b1;
      end
      WR_H4: begin
        addr     = ADDR_H4;
        wdata    = BLANK;
        wr_state = 1'b1;
      end
      WR_H5: begin
        addr     = ADDR_H5;
        wdata    = BLANK;
        wr_state = 1'b1;
      end
      WR_LED: begin
        addr     = ADDR_LED;
        wdata    = {22'b0, sw_snap};
        wr_state = 1'b1;
      end
      default: ;
    endcase
  end

  assign we   = wr_state & grant;
  assign busy = (state != IDLE);
  assign req  = busy;
  assign done = (state == DONE);

  always_ff @(posedge ram_clock or negedge resetn) begin
    if (!resetn) begin
      sw_snap  <= '0;
      key_snap <= '0;
      pass_cnt <= '0;
    end else begin
      if (state == WT_SW && grant)  sw_snap  <= rdata[9:0];
      if (state == WT_KEY && grant) key_snap <= rdata[3:1];
      if (state == DONE)            pass_cnt <= pass_cnt + 8'd1;
    end
  end

endmodule
